// File: rtl/bird_motion_controller.sv
// bird_motion_controller: frame-rate bird physics and READY/FLYING/DYING/DEAD sequencing.
// Optional READY hover bob is enabled by defining BIRD_HOVER_EN.
module bird_motion_controller #(
    parameter int SCREEN_HEIGHT = 480,
    parameter int BIRD_HEIGHT   = 35,
    parameter int GROUND_Y      = 440,
    parameter int START_Y       = 200,
    parameter int FLAP_VEL      = 8,
    parameter int GRAVITY       = 1,
    parameter int MAX_FALL_VEL  = 10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        frame_tick_i,
    input  logic        flap_i,
    input  logic        collision_i,
    input  logic        start_i,
    output logic [31:0] bird_reg_o,
    output logic [1:0]  bird_state_o,
    output logic        game_over_o
);
    typedef enum logic [1:0] {READY, FLYING, DYING, DEAD} state_t;
    localparam int FLOOR_I = (GROUND_Y < SCREEN_HEIGHT ? GROUND_Y : SCREEN_HEIGHT) - BIRD_HEIGHT;
    localparam logic signed [10:0] Y_MAX   = 11'(FLOOR_I);
    localparam logic [8:0]         Y_START = 9'(START_Y);
    localparam logic signed [7:0]  V_FLAP  = 8'(-FLAP_VEL);
    localparam logic signed [7:0]  V_GRAV  = 8'(GRAVITY);
    localparam logic signed [7:0]  V_MAX   = 8'(MAX_FALL_VEL);

    state_t             state_q;
    logic [8:0]         y_q;
    logic signed [7:0]  vel_q;
    logic               flap_pend_q, hit_q, game_over_q;
`ifdef BIRD_HOVER_EN
    logic               hov_div_q, hov_up_q;
`endif

    logic               flap_now, dying, moving, ceil, ground;
    logic signed [7:0]  v_base, v_grav, vel_n;
    logic signed [10:0] y_sum;

    always_comb begin
        flap_now = flap_pend_q | flap_i | (state_q == READY && start_i);
        dying    = state_q == DYING || (state_q == FLYING && (hit_q || collision_i));
        moving   = state_q == FLYING || state_q == DYING || (state_q == READY && flap_now);
        v_base   = (dying && vel_q < 0) ? '0 : vel_q;
        v_grav   = v_base + V_GRAV;
        vel_n    = (flap_now && !dying) ? V_FLAP : (v_grav > V_MAX ? V_MAX : v_grav);
        y_sum    = $signed({2'b00, y_q}) + $signed({{3{vel_n[7]}}, vel_n});
        ceil     = y_sum < 0;
        ground   = y_sum >= Y_MAX;
    end

    // start from DEAD behaves like a synchronous copy of the reset values
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= READY;
            y_q         <= Y_START;
            vel_q       <= '0;
            flap_pend_q <= 1'b0;
            hit_q       <= 1'b0;
            game_over_q <= 1'b0;
`ifdef BIRD_HOVER_EN
            hov_div_q   <= 1'b0;
            hov_up_q    <= 1'b1;
`endif
        end else if (state_q == DEAD && start_i) begin
            state_q     <= READY;
            y_q         <= Y_START;
            vel_q       <= '0;
            flap_pend_q <= 1'b0;
            hit_q       <= 1'b0;
            game_over_q <= 1'b0;
`ifdef BIRD_HOVER_EN
            hov_div_q   <= 1'b0;
            hov_up_q    <= 1'b1;
`endif
        end else begin
            hit_q       <= hit_q | collision_i;
            flap_pend_q <= frame_tick_i ? 1'b0 : flap_now;
            if (frame_tick_i && moving) begin
                if (ground) begin
                    y_q         <= Y_MAX[8:0];
                    vel_q       <= '0;
                    state_q     <= DEAD;
                    game_over_q <= 1'b1;
                end else if (ceil) begin
                    y_q     <= '0;
                    vel_q   <= '0;
                    state_q <= dying ? DYING : FLYING;
                end else begin
                    y_q     <= y_sum[8:0];
                    vel_q   <= vel_n;
                    state_q <= dying ? DYING : FLYING;
                end
            end
`ifdef BIRD_HOVER_EN
            else if (frame_tick_i && state_q == READY) begin
                hov_div_q <= ~hov_div_q;
                if (hov_div_q) begin
                    y_q <= hov_up_q ? y_q - 9'd1 : y_q + 9'd1;
                    if (y_q == (hov_up_q ? Y_START - 9'd3 : Y_START + 9'd3)) hov_up_q <= ~hov_up_q;
                end
            end
`endif
        end
    end

    assign bird_reg_o   = {23'b0, y_q};
    assign bird_state_o = state_q;
    assign game_over_o  = game_over_q;
endmodule
